dwr_arb: RTL and testbench
==========================

Name: dwr_arb

Overview:
- DDR write arbiter: the responder side of the dwr_req/dwr_ack/dwr_vout/dwr_dout interface used by the vision pipeline blocks (gftt_obuf, rectification output, etc.).
- Grants one client at a time in round-robin order.
- Collects that client's burst (address word, length word, data beats) into a burst FIFO.
- Replays the burst as a single write transaction on the memory-side AW/W/B interface toward the PS DDR port.

Parameters:
- N_CLI, 4, number of client ports (2..8).
- FIFO_AW, 8, log2 of burst FIFO depth. Depth 256 is the maximum burst, bst_len_m1 = 255.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cli_req  in  N_CLI  per-client write request, level
- cli_ack  out  N_CLI  per-client grant, one-cycle pulse
- cli_vin  in  N_CLI  per-client beat valid (client's dwr_vout)
- cli_din  in  32*N_CLI  per-client beat data, client i at [32i+31:32i]
- m_awvalid  out  1  write address valid
- m_awready  in  1  write address ready
- m_awaddr  out  32  burst byte address
- m_awlen  out  8  beats minus one
- m_wvalid  out  1  write data valid
- m_wready  in  1  write data ready
- m_wdata  out  32  write data
- m_wlast  out  1  last beat of burst
- m_bvalid  in  1  write response valid
- m_bready  out  1  write response ready
- busy  out  1  arbiter not in IDLE
- err  out  1  sticky protocol error
- err_clr  in  1  clears err

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer rr = 0; FIFO empty.
- Client protocol:
  - Client holds req high.
  - Arbiter pulses ack for exactly 1 cycle.
  - Beat 0 on vin is the 32-bit byte address. Beat 1 is {24'b0, len_m1}. Then len_m1+1 data beats follow.
  - Beats may have idle gaps. There is no backpressure toward the client.
  - The client drops req on the cycle after ack at the latest. The arbiter ignores the granted client's req until it returns to IDLE.
- States:
  - IDLE: if any req, pick the lowest index at or above rr, wrapping. Go to GRANT.
  - GRANT: ack[g] = 1 for one cycle; rr <= g+1 mod N_CLI. Go to HADDR.
  - HADDR: on vin[g], latch m_awaddr. Go to HLEN.
  - HLEN: on vin[g], latch m_awlen = din[7:0]; clear beat counters; assert m_awvalid. Go to DATA.
  - DATA: each vin[g] beat is pushed to the FIFO and increments rx_cnt.
    - m_awvalid is held until m_awready.
    - The W channel pops the FIFO whenever it is non-empty, AW has been accepted or is accepted in the same cycle, and m_wready is high.
    - m_wlast = 1 when tx_cnt == m_awlen.
    - When the wlast beat is accepted, go to RESP. rx_cnt must already equal len_m1+1.
  - RESP: m_bready = 1. On m_bvalid, go to IDLE.
- Latency: ack is asserted 1 cycle after req is sampled in IDLE. The first m_wvalid can rise the cycle after the first data beat is pushed.
- Simultaneous push and pop in one cycle are allowed; FIFO occupancy is unchanged.
- FIFO cannot overflow: depth is at least len_m1+1 and only one burst is in flight. The FIFO is combinational-read (FWFT).
- Error conditions (sticky err = 1):
  - vin from a non-granted client, or any vin while in IDLE/GRANT/RESP. The beat is discarded.
  - vin[g] beyond len_m1+1 data beats. The beat is discarded.
- err_clr clears err. If err_clr and a new error occur in the same cycle, err stays 1.
- N_CLI == 1 degenerates to a plain grant with no rotation.
- Reset mid-burst aborts immediately: the FIFO is flushed and all outputs return to reset values. Clients are reset by the same rst_n.
- No 4 KB boundary splitting; clients guarantee aligned bursts.

Decomposition:
- Package dvp_pkg:
  - state enum constants IDLE, GRANT, HADDR, HLEN, DATA, RESP;
  - beat-type constants HDR_ADDR = 0, HDR_LEN = 1.
- Sub-module dwr_arb_fifo: synchronous FWFT FIFO, 32-bit wide, depth 2^FIFO_AW, with push/pop/empty/full/flush.
- Round-robin select stays inline.

Test Plan:
- Single burst: client 1 sends addr 0x3000_0000, len_m1 = 3, data 0..3 with m_awready/m_wready tied 1 and bvalid 2 cycles after wlast. Expect ack[1] pulse 1 cycle, awaddr 0x3000_0000, awlen 3, wdata 0,1,2,3 with wlast on beat 3, busy low after bvalid.
- Round-robin: all 4 reqs asserted continuously, len_m1 = 0. Grants in order 0,1,2,3,0. After the first grant to 2, the next grant goes to 3, not 0.
- Backpressure: len_m1 = 255, m_wready toggles 1/0 and m_awready is delayed 10 cycles. All 256 words arrive in order, no err, wlast only on beat 255.
- Gapped input: client inserts 3 idle cycles between every beat, len_m1 = 7. Output data matches, and m_wvalid drops when the FIFO is empty.
- Protocol error: client 2 asserts vin while client 0 is granted. err = 1 and the data stream is unaffected. err_clr pulse sets err = 0.
- Reset mid-burst: rst_n low after 5 of 16 data beats. All outputs are 0 next cycle, and a subsequent clean burst completes correctly.

Source files
------------

// File: rtl/dvp_pkg.sv
// Shared constants for the DDR write arbiter: FSM encodings, header beat
// indices and the round-robin pick helper.
package dvp_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] GRANT = 3'd1;
  localparam logic [2:0] HADDR = 3'd2;
  localparam logic [2:0] HLEN  = 3'd3;
  localparam logic [2:0] DATA  = 3'd4;
  localparam logic [2:0] RESP  = 3'd5;

  localparam int HDR_ADDR = 0;
  localparam int HDR_LEN  = 1;

  // Lowest requesting index at or above rr, wrapping at n (n <= 8).
  // Returns rr when nothing is requesting; callers gate on |req.
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] rr,
                                         input logic [3:0] n);
    logic [2:0] sel;
    logic       found;
    logic [3:0] idx;
    sel   = rr;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = 4'(rr) + 4'(i);
      if (idx >= n) idx = idx - n;
      if (!found && (4'(i) < n) && req[idx[2:0]]) begin
        sel   = idx[2:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/dwr_arb_fifo.sv
// Burst FIFO: first-word-fall-through, combinational read of the head entry.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module dwr_arb_fifo #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full
);

  logic [DW-1:0] mem [2**AW];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr[AW-1:0]];

  // Pointer update; flush discards everything, including a same-cycle push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/dwr_arb.sv
// DDR write arbiter: grants one client at a time (round-robin), gathers its
// address/length header and data beats into the burst FIFO, and replays the
// burst as one AW/W/B write transaction toward the DDR port.
//
// state | meaning
// IDLE  | waiting for any client request
// GRANT | ack pulse to the chosen client, rotate round-robin pointer
// HADDR | waiting for header beat 0 (byte address)
// HLEN  | waiting for header beat 1 (len_m1), then raise AW
// DATA  | push client beats into FIFO, drain FIFO onto W
// RESP  | wait for the write response
module dwr_arb
  import dvp_pkg::*;
#(
  parameter int N_CLI   = 4,
  parameter int FIFO_AW = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CLI-1:0]    cli_req,
  output logic [N_CLI-1:0]    cli_ack,
  input  logic [N_CLI-1:0]    cli_vin,
  input  logic [32*N_CLI-1:0] cli_din,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [31:0]         m_awaddr,
  output logic [7:0]          m_awlen,
  output logic                m_wvalid,
  input  logic                m_wready,
  output logic [31:0]         m_wdata,
  output logic                m_wlast,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic                busy,
  output logic                err,
  input  logic                err_clr
);

  localparam int GW = (N_CLI > 1) ? $clog2(N_CLI) : 1;

  logic [2:0]       state;
  logic [GW-1:0]    g;
  logic [GW-1:0]    rr;
  logic             aw_done;
  logic [8:0]       rx_cnt;
  logic [7:0]       tx_cnt;

  logic [7:0]       req_ext;
  logic [N_CLI-1:0] g_onehot;
  logic             vin_g;
  logic [31:0]      din_g;
  logic             rx_room;
  logic             push;
  logic             pop;
  logic             aw_ok;
  logic             stray;
  logic             ovf;
  logic             fifo_flush;
  logic [31:0]      fifo_dout;
  logic             fifo_empty;
  logic             fifo_full;

  // Zero-extend requests to the 8-wide helper and one-hot the current grant.
  always_comb begin
    req_ext                = '0;
    req_ext[N_CLI-1:0]     = cli_req;
    g_onehot               = '0;
    g_onehot[g]            = 1'b1;
  end

  assign vin_g   = cli_vin[g];
  assign din_g   = cli_din[32*g +: 32];
  assign rx_room = (rx_cnt <= {1'b0, m_awlen});
  assign push    = (state == DATA) && vin_g && rx_room;

  // A beat is stray if it comes from anyone but the granted client, or
  // arrives when no header/data beat is expected at all.
  assign stray = ((state == HADDR) || (state == HLEN) || (state == DATA))
                 ? |(cli_vin & ~g_onehot) : |cli_vin;
  assign ovf   = (state == DATA) && vin_g && (!rx_room || fifo_full);

  // W may only move once AW is accepted (earlier, or on this very cycle).
  assign aw_ok    = aw_done || (m_awvalid && m_awready);
  assign m_wvalid = (state == DATA) && !fifo_empty && aw_ok;
  assign pop      = m_wvalid && m_wready;
  assign m_wlast  = m_wvalid && (tx_cnt == m_awlen);
  assign m_wdata  = m_wvalid ? fifo_dout : 32'd0;

  assign cli_ack    = (state == GRANT) ? g_onehot : '0;
  assign m_bready   = (state == RESP);
  assign busy       = (state != IDLE);
  assign fifo_flush = (state == HLEN) && vin_g;

  dwr_arb_fifo #(
    .AW (FIFO_AW),
    .DW (32)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (fifo_flush),
    .push  (push),
    .din   (din_g),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Main sequencer: grant, header capture, data transfer, response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      g         <= '0;
      rr        <= '0;
      m_awaddr  <= '0;
      m_awlen   <= '0;
      m_awvalid <= 1'b0;
      aw_done   <= 1'b0;
      rx_cnt    <= '0;
      tx_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|cli_req) begin
            g     <= GW'(rr_pick(req_ext, 3'(rr), 4'(N_CLI)));
            state <= GRANT;
          end
        end
        GRANT: begin
          rr    <= (g == GW'(N_CLI - 1)) ? '0 : g + 1'b1;
          state <= HADDR;
        end
        HADDR: begin
          if (vin_g) begin
            m_awaddr <= din_g;
            state    <= HLEN;
          end
        end
        HLEN: begin
          if (vin_g) begin
            m_awlen   <= din_g[7:0];
            rx_cnt    <= '0;
            tx_cnt    <= '0;
            m_awvalid <= 1'b1;
            aw_done   <= 1'b0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (m_awvalid && m_awready) begin
            m_awvalid <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (push) rx_cnt <= rx_cnt + 9'd1;
          if (pop)  tx_cnt <= tx_cnt + 8'd1;
          if (pop && m_wlast) state <= RESP;
        end
        RESP: begin
          if (m_bvalid) begin
            aw_done <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky error flag; a new error in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= (err && !err_clr) || stray || ovf;
  end

endmodule

// File: tb/tb_dwr_arb.sv
// Directed bench for dwr_arb with a small AW/W/B memory-side responder.
module tb_dwr_arb;

  localparam int N_CLI = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   cli_req;
  logic [3:0]   cli_ack;
  logic [3:0]   cli_vin;
  logic [127:0] cli_din;
  logic         m_awvalid, m_awready;
  logic [31:0]  m_awaddr;
  logic [7:0]   m_awlen;
  logic         m_wvalid, m_wready;
  logic [31:0]  m_wdata;
  logic         m_wlast;
  logic         m_bvalid, m_bready;
  logic         busy, err, err_clr;

  int checks = 0;
  int errors = 0;

  logic [31:0] wq[$];
  logic        wl_q[$];
  logic [31:0] aw_addr_q[$];
  logic [7:0]  aw_len_q[$];
  int          wv_fall = 0;
  logic        wv_prev = 1'b0;
  int          last_cnt = 0;
  int          last_seen = 0;
  int          aw_wait = 0;
  int          b_wait = 0;
  int          aw_delay = 0;
  bit          w_toggle = 1'b0;

  always #5 clk = ~clk;

  dwr_arb #(.N_CLI(N_CLI), .FIFO_AW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cli_req   (cli_req),
    .cli_ack   (cli_ack),
    .cli_vin   (cli_vin),
    .cli_din   (cli_din),
    .m_awvalid (m_awvalid),
    .m_awready (m_awready),
    .m_awaddr  (m_awaddr),
    .m_awlen   (m_awlen),
    .m_wvalid  (m_wvalid),
    .m_wready  (m_wready),
    .m_wdata   (m_wdata),
    .m_wlast   (m_wlast),
    .m_bvalid  (m_bvalid),
    .m_bready  (m_bready),
    .busy      (busy),
    .err       (err),
    .err_clr   (err_clr)
  );

  // Record memory-side handshakes half a cycle away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_awvalid && m_awready) begin
        aw_addr_q.push_back(m_awaddr);
        aw_len_q.push_back(m_awlen);
      end
      if (m_wvalid && m_wready) begin
        wq.push_back(m_wdata);
        wl_q.push_back(m_wlast);
        if (m_wlast) last_cnt++;
      end
      if (wv_prev && !m_wvalid) wv_fall++;
      wv_prev = m_wvalid;
    end else begin
      wv_prev = 1'b0;
    end
  end

  // Memory responder: AW ready after aw_delay cycles, W ready steady or
  // toggling, one-cycle B response two cycles after the last beat.
  initial begin
    m_awready = 1'b0;
    m_wready  = 1'b0;
    m_bvalid  = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        m_awready = 1'b0;
        m_wready  = 1'b0;
        m_bvalid  = 1'b0;
        aw_wait   = 0;
        b_wait    = 0;
        last_seen = last_cnt;
      end else begin
        if (m_awvalid) aw_wait++;
        else           aw_wait = 0;
        m_awready = (aw_wait > aw_delay);
        m_wready  = w_toggle ? ~m_wready : 1'b1;
        if (m_bvalid) m_bvalid = 1'b0;
        else if (last_seen != last_cnt) begin
          b_wait++;
          if (b_wait >= 2) begin
            m_bvalid  = 1'b1;
            b_wait    = 0;
            last_seen++;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500us");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    wq.delete();
    wl_q.delete();
    aw_addr_q.delete();
    aw_len_q.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {84'd0, cli_ack, m_awvalid, m_wvalid, m_wlast, m_bready, busy, err, m_bready},
          96'd0);
    check({tag, "_awaddr"}, {64'd0, m_awaddr}, 96'd0);
    check({tag, "_awlen"}, {88'd0, m_awlen}, 96'd0);
    check({tag, "_wdata"}, {64'd0, m_wdata}, 96'd0);
  endtask

  // Wait (bounded) for an ack, report who got it and the latency, then
  // confirm the ack is a single-cycle pulse.
  task automatic grant_wait(input string tag, input bit drop, output int gi, output int lat);
    int k;
    k  = 0;
    gi = 0;
    while (cli_ack == 4'd0 && k < 50) begin
      step();
      k++;
    end
    lat = k;
    check({tag, "_ack_onehot"}, 96'($countones(cli_ack)), 96'd1);
    for (int i = 0; i < N_CLI; i++) if (cli_ack[i]) gi = i;
    if (drop) cli_req[gi] = 1'b0;
    step();
    check({tag, "_ack_pulse"}, 96'(cli_ack), 96'd0);
  endtask

  task automatic beat(input int c, input logic [31:0] val, input int gap);
    cli_vin[c] = 1'b1;
    cli_din[32*c +: 32] = val;
    step();
    cli_vin[c] = 1'b0;
    repeat (gap) step();
  endtask

  task automatic send_beats(input int c, input logic [31:0] addr, input int len,
                            input int gap, input logic [31:0] base);
    beat(c, addr, gap);
    beat(c, 32'(len), gap);
    for (int k = 0; k <= len; k++) beat(c, base + 32'(k), gap);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 3000) begin
      step();
      k++;
    end
    check({tag, "_idle"}, 96'(busy), 96'd0);
  endtask

  task automatic check_burst(input string tag, input logic [31:0] addr, input int len,
                             input logic [31:0] base);
    int nl;
    check({tag, "_aw_n"}, 96'(aw_addr_q.size()), 96'd1);
    if (aw_addr_q.size() > 0) begin
      check({tag, "_awaddr"}, 96'(aw_addr_q[0]), 96'(addr));
      check({tag, "_awlen"}, 96'(aw_len_q[0]), 96'(len));
    end
    check({tag, "_w_n"}, 96'(wq.size()), 96'(len + 1));
    nl = 0;
    for (int k = 0; k < wq.size(); k++) begin
      if (wl_q[k]) nl++;
      if (k <= len) begin
        check($sformatf("%s_d%0d", tag, k), 96'(wq[k]), 96'(base + 32'(k)));
        check($sformatf("%s_l%0d", tag, k), 96'(wl_q[k]), 96'(k == len));
      end
    end
    check({tag, "_nlast"}, 96'(nl), 96'd1);
  endtask

  initial begin
    int gi, lat;
    int exp_rr[5];
    exp_rr = '{0, 1, 2, 3, 0};
    rst_n   = 1'b0;
    cli_req = '0;
    cli_vin = '0;
    cli_din = '0;
    err_clr = 1'b0;
    repeat (3) step();
    check_zero("reset");
    rst_n = 1'b1;
    step();

    // Round-robin with every client requesting continuously.
    cli_req = 4'hF;
    for (int r = 0; r < 5; r++) begin
      clear_q();
      grant_wait($sformatf("rr%0d", r), 1'b0, gi, lat);
      check($sformatf("rr%0d_grant", r), 96'(gi), 96'(exp_rr[r]));
      check($sformatf("rr%0d_lat", r), 96'(lat), 96'd1);
      if (r == 4) cli_req = '0;
      send_beats(gi, 32'h1000_0000 + 32'(r * 64), 0, 0, 32'(r * 100));
      wait_idle($sformatf("rr%0d", r));
      check_burst($sformatf("rr%0d", r), 32'h1000_0000 + 32'(r * 64), 0, 32'(r * 100));
    end

    // Single burst from client 1.
    clear_q();
    cli_req[1] = 1'b1;
    grant_wait("single", 1'b1, gi, lat);
    check("single_grant", 96'(gi), 96'd1);
    check("single_lat", 96'(lat), 96'd1);
    send_beats(1, 32'h3000_0000, 3, 0, 32'd0);
    wait_idle("single");
    check_burst("single", 32'h3000_0000, 3, 32'd0);
    check("single_err", 96'(err), 96'd0);

    // Maximum burst with W backpressure and late AW ready.
    clear_q();
    aw_delay = 10;
    w_toggle = 1'b1;
    cli_req[3] = 1'b1;
    grant_wait("bp", 1'b1, gi, lat);
    check("bp_grant", 96'(gi), 96'd3);
    send_beats(3, 32'h2000_0000, 255, 0, 32'hA000_0000);
    wait_idle("bp");
    check_burst("bp", 32'h2000_0000, 255, 32'hA000_0000);
    check("bp_err", 96'(err), 96'd0);
    aw_delay = 0;
    w_toggle = 1'b0;

    // Gapped input: each beat drains immediately, so wvalid pulses per beat.
    clear_q();
    wv_fall = 0;
    cli_req[2] = 1'b1;
    grant_wait("gap", 1'b1, gi, lat);
    check("gap_grant", 96'(gi), 96'd2);
    send_beats(2, 32'h4000_0100, 7, 3, 32'h0000_5500);
    wait_idle("gap");
    check_burst("gap", 32'h4000_0100, 7, 32'h0000_5500);
    check("gap_wv_fall", 96'(wv_fall), 96'd8);

    // Stray beat from client 2 while client 0 holds the grant.
    clear_q();
    cli_req[0] = 1'b1;
    grant_wait("perr", 1'b1, gi, lat);
    check("perr_grant", 96'(gi), 96'd0);
    beat(0, 32'h5000_0000, 1);
    beat(0, 32'd3, 1);
    beat(0, 32'h0000_0C00, 1);
    check("perr_err_pre", 96'(err), 96'd0);
    beat(2, 32'hDEAD_BEEF, 0);
    check("perr_err_set", 96'(err), 96'd1);
    for (int k = 1; k <= 3; k++) beat(0, 32'h0000_0C00 + 32'(k), 1);
    wait_idle("perr");
    check_burst("perr", 32'h5000_0000, 3, 32'h0000_0C00);
    check("perr_sticky", 96'(err), 96'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("perr_clr", 96'(err), 96'd0);

    // Extra beat past len_m1+1 is discarded and flagged.
    clear_q();
    cli_req[0] = 1'b1;
    grant_wait("ovf", 1'b1, gi, lat);
    send_beats(0, 32'h5000_1000, 1, 0, 32'h0000_0E00);
    beat(0, 32'hBAD0_BAD0, 0);
    check("ovf_err", 96'(err), 96'd1);
    wait_idle("ovf");
    check_burst("ovf", 32'h5000_1000, 1, 32'h0000_0E00);

    // Clear and a new error in the same cycle: error wins.
    err_clr = 1'b1;
    cli_vin[3] = 1'b1;
    step();
    cli_vin[3] = 1'b0;
    check("clr_vs_err", 96'(err), 96'd1);
    step();
    err_clr = 1'b0;
    check("clr_only", 96'(err), 96'd0);

    // Reset after 5 of 16 data beats, then a clean burst.
    clear_q();
    cli_req[1] = 1'b1;
    grant_wait("rst", 1'b1, gi, lat);
    beat(1, 32'h6000_0000, 0);
    beat(1, 32'd15, 0);
    for (int k = 0; k < 5; k++) beat(1, 32'h0000_7700 + 32'(k), 0);
    rst_n   = 1'b0;
    cli_req = '0;
    cli_vin = '0;
    #1;
    check_zero("rst_mid");
    step();
    step();
    rst_n = 1'b1;
    step();
    check_zero("rst_after");
    clear_q();
    cli_req[1] = 1'b1;
    grant_wait("clean", 1'b1, gi, lat);
    check("clean_grant", 96'(gi), 96'd1);
    send_beats(1, 32'h6000_0000, 15, 0, 32'h0000_8800);
    wait_idle("clean");
    check_burst("clean", 32'h6000_0000, 15, 32'h0000_8800);
    check("clean_err", 96'(err), 96'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
